// File: rtl/axi_lite_selftest_master_if.sv
// AXI4-Lite bus bundle between the register self-test master and the slave under test.
interface axi_lite_selftest_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_selftest_master.sv
// AXI4-Lite register self-test master: writes a seeded pattern to NUM_REGS slave
// registers, reads each back and reports error count, first failing address and timeouts.
//
// state   | meaning
// IDLE    | waiting for start; status outputs hold the last result
// WR_REQ  | awvalid/wvalid up until each channel is accepted
// WR_RESP | bready up, waiting for the write response
// RD_REQ  | arvalid up until accepted
// RD_RESP | rready up, waiting for read data to compare
// FINISH  | one cycle: done pulse, pass valid
module axi_lite_selftest_master #(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter int                            NUM_REGS           = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
  parameter int                            ADDR_STRIDE        = 4,
  parameter int                            MODE               = 0,
  parameter logic [31:0]                   PATTERN_SEED       = 32'h0101FFFF,
  parameter logic [31:0]                   PATTERN_INC        = 32'h10101010,
  parameter int                            TIMEOUT_CYCLES     = 1024
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [15:0]                   err_count,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] first_err_addr,
  output logic                          timeout,
  axi_lite_selftest_master_if.master    m_axi
);
  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int DW    = C_M_AXI_DATA_WIDTH;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [AW-1:0]    addr_q, addr_nxt;
  logic [DW-1:0]    data_q, data_nxt;
  logic             aw_ok, aw_ok_nxt, w_ok, w_ok_nxt;
  logic [TMR_W-1:0] tmr;
  logic [15:0]      err_q, err_nxt;
  logic [AW-1:0]    first_q, first_nxt;
  logic             pass_q, pass_nxt, tout_q, tout_nxt;
  logic [1:0]       n_err;
  logic [16:0]      err_sum;
  logic             adv, rewind, waiting, last;
  logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign waiting = (state == WR_REQ) || (state == WR_RESP) || (state == RD_REQ) || (state == RD_RESP);
  assign last    = (idx == LAST_IDX);
  assign aw_hs   = m_axi.awvalid && m_axi.awready;
  assign w_hs    = m_axi.wvalid && m_axi.wready;
  assign b_hs    = m_axi.bvalid && m_axi.bready;
  assign ar_hs   = m_axi.arvalid && m_axi.arready;
  assign r_hs    = m_axi.rvalid && m_axi.rready;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    aw_ok_nxt = aw_ok;
    w_ok_nxt  = w_ok;
    err_nxt   = err_q;
    first_nxt = first_q;
    pass_nxt  = pass_q;
    tout_nxt  = tout_q;
    n_err     = 2'd0;
    err_sum   = '0;
    adv       = 1'b0;
    rewind    = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = WR_REQ;
        rewind    = 1'b1;
        err_nxt   = '0;
        first_nxt = '0;
        pass_nxt  = 1'b0;
        tout_nxt  = 1'b0;
      end
      WR_REQ: begin
        if (aw_hs) aw_ok_nxt = 1'b1;
        if (w_hs)  w_ok_nxt  = 1'b1;
        if ((aw_ok || aw_hs) && (w_ok || w_hs)) begin
          state_nxt = WR_RESP;
          aw_ok_nxt = 1'b0;
          w_ok_nxt  = 1'b0;
        end
      end
      WR_RESP: if (b_hs) begin
        n_err = 2'(m_axi.bresp != 2'b00);
        if (MODE == 0) begin
          state_nxt = RD_REQ;
        end else if (last) begin
          state_nxt = RD_REQ;
          rewind    = 1'b1;
        end else begin
          state_nxt = WR_REQ;
          adv       = 1'b1;
        end
      end
      RD_REQ: if (ar_hs) state_nxt = RD_RESP;
      RD_RESP: if (r_hs) begin
        n_err = 2'(m_axi.rresp != 2'b00) + 2'(m_axi.rdata != data_q);
        if (last) begin
          state_nxt = FINISH;
        end else begin
          adv       = 1'b1;
          state_nxt = (MODE == 0) ? WR_REQ : RD_REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A wait state that is about to stay put with the timer expired aborts the run.
    if (waiting && (state_nxt == state) && (tmr == '0)) begin
      state_nxt = FINISH;
      tout_nxt  = 1'b1;
      n_err     = 2'd1;
      aw_ok_nxt = 1'b0;
      w_ok_nxt  = 1'b0;
    end

    if (n_err != 2'd0) begin
      if (err_q == '0) first_nxt = addr_q;
      err_sum = {1'b0, err_q} + 17'(n_err);
      err_nxt = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
    if (adv) begin
      idx_nxt  = idx + IDX_W'(1);
      addr_nxt = addr_q + AW'(ADDR_STRIDE);
      data_nxt = data_q + DW'(PATTERN_INC);
    end
    if (rewind) begin
      idx_nxt  = '0;
      addr_nxt = BASE_ADDR;
      data_nxt = DW'(PATTERN_SEED);
    end
    if (state_nxt == FINISH) pass_nxt = (err_nxt == '0);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= IDLE;
      idx     <= '0;
      addr_q  <= BASE_ADDR;
      data_q  <= DW'(PATTERN_SEED);
      aw_ok   <= 1'b0;
      w_ok    <= 1'b0;
      tmr     <= TMR_INIT;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      addr_q  <= addr_nxt;
      data_q  <= data_nxt;
      aw_ok   <= aw_ok_nxt;
      w_ok    <= w_ok_nxt;
      err_q   <= err_nxt;
      first_q <= first_nxt;
      pass_q  <= pass_nxt;
      tout_q  <= tout_nxt;
      if (state_nxt != state) tmr <= TMR_INIT;
      else if (tmr != '0)     tmr <= tmr - TMR_W'(1);
    end
  end

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = (state == WR_REQ) && !aw_ok;
  assign m_axi.wdata   = data_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = (state == WR_REQ) && !w_ok;
  assign m_axi.bready  = (state == WR_RESP);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = (state == RD_REQ);
  assign m_axi.rready  = (state == RD_RESP);

  assign busy           = waiting;
  assign done           = (state == FINISH);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign timeout        = tout_q;
endmodule

// File: tb/tb_axi_lite_selftest_master.sv
// Directed bench: two masters (MODE0/4 regs/timeout 16, MODE1/8 regs) share one muxed RAM slave model.
`timescale 1ns/1ps
module tb_axi_lite_selftest_master;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;

  logic        start0 = 1'b0, start1 = 1'b0;
  logic        busy0, done0, pass0, tout0, busy1, done1, pass1, tout1;
  logic [15:0] errc0, errc1;
  logic [31:0] fea0, fea1;

  axi_lite_selftest_master_if #(.ADDR_W(32), .DATA_W(32)) m0 ();
  axi_lite_selftest_master_if #(.ADDR_W(32), .DATA_W(32)) m1 ();

  axi_lite_selftest_master #(.NUM_REGS(4), .MODE(0), .TIMEOUT_CYCLES(16)) dut0 (
    .ACLK(ACLK), .ARESET(ARESET), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(errc0), .first_err_addr(fea0), .timeout(tout0), .m_axi(m0));

  axi_lite_selftest_master #(.NUM_REGS(8), .MODE(1)) dut1 (
    .ACLK(ACLK), .ARESET(ARESET), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(errc1), .first_err_addr(fea1), .timeout(tout1), .m_axi(m1));

  // slave configuration
  logic        sel = 1'b0;
  logic        rnd = 1'b0;
  logic        ar_stuck = 1'b0;
  logic [31:0] corrupt_addr = 32'hFFFF_FFF0, werr_addr = 32'hFFFF_FFF0, rerr_addr = 32'hFFFF_FFF0;

  logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;

  assign s_awvalid = sel ? m1.awvalid : m0.awvalid;
  assign s_awaddr  = sel ? m1.awaddr  : m0.awaddr;
  assign s_wvalid  = sel ? m1.wvalid  : m0.wvalid;
  assign s_wdata   = sel ? m1.wdata   : m0.wdata;
  assign s_bready  = sel ? m1.bready  : m0.bready;
  assign s_arvalid = sel ? m1.arvalid : m0.arvalid;
  assign s_araddr  = sel ? m1.araddr  : m0.araddr;
  assign s_rready  = sel ? m1.rready  : m0.rready;

  assign m0.awready = !sel && s_awready;
  assign m1.awready =  sel && s_awready;
  assign m0.wready  = !sel && s_wready;
  assign m1.wready  =  sel && s_wready;
  assign m0.bvalid  = !sel && s_bvalid;
  assign m1.bvalid  =  sel && s_bvalid;
  assign m0.arready = !sel && s_arready;
  assign m1.arready =  sel && s_arready;
  assign m0.rvalid  = !sel && s_rvalid;
  assign m1.rvalid  =  sel && s_rvalid;
  assign m0.bresp = s_bresp;
  assign m1.bresp = s_bresp;
  assign m0.rresp = s_rresp;
  assign m1.rresp = s_rresp;
  assign m0.rdata = s_rdata;
  assign m1.rdata = s_rdata;

  logic [31:0] mem [0:63];
  logic [31:0] wlog_a [0:15];
  logic [31:0] wlog_d [0:15];
  logic        aw_got, w_got, ar_got, aw_first, w_first, ilv_bad;
  logic [31:0] aw_a, w_d, ar_a;
  int aw_wait, w_wait, b_wait, ar_wait, r_wait, b_tgt, ar_tgt, r_tgt;
  int aw_cnt, w_cnt, ar_cnt, r_cnt, wl_cnt, ar_hi, aw_at_ar;

  // AW/W readiness alternates 0/3 cycles so both arrival orders occur in random mode.
  always @(posedge ACLK) begin
    if (ARESET) begin
      s_awready <= 0; s_wready <= 0; s_bvalid <= 0; s_bresp <= 0;
      s_arready <= 0; s_rvalid <= 0; s_rresp <= 0; s_rdata <= 0;
      aw_got <= 0; w_got <= 0; ar_got <= 0; aw_a <= 0; w_d <= 0; ar_a <= 0;
      aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
      b_tgt <= 0; ar_tgt <= 0; r_tgt <= 0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0; wl_cnt <= 0; ar_hi <= 0; aw_at_ar <= -1;
      aw_first <= 0; w_first <= 0; ilv_bad <= 0;
    end else begin
      if (s_awvalid && s_awready) begin
        s_awready <= 0; aw_got <= 1; aw_a <= s_awaddr; aw_cnt <= aw_cnt + 1; aw_wait <= 0;
        if (w_got) w_first <= 1;
      end else if (s_awvalid) begin
        if (aw_wait >= ((rnd && aw_cnt[0]) ? 3 : 0)) s_awready <= 1;
        else aw_wait <= aw_wait + 1;
      end
      if (s_wvalid && s_wready) begin
        s_wready <= 0; w_got <= 1; w_d <= s_wdata; w_cnt <= w_cnt + 1; w_wait <= 0;
        if (aw_got) aw_first <= 1;
      end else if (s_wvalid) begin
        if (w_wait >= ((rnd && !w_cnt[0]) ? 3 : 0)) s_wready <= 1;
        else w_wait <= w_wait + 1;
      end
      if (s_bvalid && s_bready) begin
        s_bvalid <= 0; aw_got <= 0; w_got <= 0; b_wait <= 0;
        b_tgt <= rnd ? int'($urandom_range(5, 0)) : 0;
      end else if (aw_got && w_got && !s_bvalid) begin
        if (b_wait >= b_tgt) begin
          s_bvalid <= 1;
          s_bresp <= (aw_a == werr_addr) ? 2'b10 : 2'b00;
          mem[aw_a[7:2]] <= w_d;
          wlog_a[wl_cnt[3:0]] <= aw_a;
          wlog_d[wl_cnt[3:0]] <= w_d;
          wl_cnt <= wl_cnt + 1;
        end else b_wait <= b_wait + 1;
      end
      if (s_arvalid) ar_hi <= ar_hi + 1;
      if (s_arvalid && s_arready) begin
        s_arready <= 0; ar_got <= 1; ar_a <= s_araddr; ar_wait <= 0; ar_cnt <= ar_cnt + 1;
        ar_tgt <= rnd ? int'($urandom_range(5, 0)) : 0;
        if (ar_cnt == 0) aw_at_ar <= aw_cnt;
        if (aw_cnt != ar_cnt + 1) ilv_bad <= 1;
      end else if (s_arvalid && !ar_stuck) begin
        if (ar_wait >= ar_tgt) s_arready <= 1;
        else ar_wait <= ar_wait + 1;
      end
      if (s_rvalid && s_rready) begin
        s_rvalid <= 0; ar_got <= 0; r_cnt <= r_cnt + 1; r_wait <= 0;
        r_tgt <= rnd ? int'($urandom_range(5, 0)) : 0;
      end else if (ar_got && !s_rvalid) begin
        if (r_wait >= r_tgt) begin
          s_rvalid <= 1;
          s_rdata <= mem[ar_a[7:2]] ^ ((ar_a == corrupt_addr) ? 32'h1 : 32'h0);
          s_rresp <= (ar_a == rerr_addr) ? 2'b10 : 2'b00;
        end else r_wait <= r_wait + 1;
      end
    end
  end

  logic [31:0] exp_d [0:3] = '{32'h0101FFFF, 32'h1112100F, 32'h2122201F, 32'h3132302F};

  task automatic cfg(input logic s, input logic r, input logic [31:0] cor, input logic [31:0] we,
                     input logic [31:0] re, input logic stuck);
    sel = s; rnd = r; corrupt_addr = cor; werr_addr = we; rerr_addr = re; ar_stuck = stuck;
    @(posedge ACLK); #1 ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
  endtask

  task automatic pulse_start(input logic which);
    @(posedge ACLK); #1;
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(posedge ACLK); #1;
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic wait_done(input logic which, input int budget, output bit got);
    got = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge ACLK); #1;
      if (which ? done1 : done0) begin got = 1; return; end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({m0.awvalid, m0.wvalid, m0.bready, m0.arvalid, m0.rready, busy0, done0, pass0, tout0} !== 9'b0) begin
      errors++; $display("FAIL reset_ctl0: got %b expected 000000000", {m0.awvalid, m0.wvalid, m0.bready, m0.arvalid, m0.rready, busy0, done0, pass0, tout0}); end
    checks++; if ({errc0, fea0} !== 48'h0) begin
      errors++; $display("FAIL reset_status0: err_count %h first_err_addr %h expected 0", errc0, fea0); end
    checks++; if ({m0.awprot, m0.arprot, m0.wstrb} !== {3'b000, 3'b000, 4'hF}) begin
      errors++; $display("FAIL fixed_outputs: got %b expected 0000001111", {m0.awprot, m0.arprot, m0.wstrb}); end
    checks++; if ({m1.awvalid, m1.arvalid, busy1, done1, pass1, tout1, errc1} !== 22'h0) begin
      errors++; $display("FAIL reset_dut1: got %h expected 0", {m1.awvalid, m1.arvalid, busy1, done1, pass1, tout1, errc1}); end
  endtask

  task automatic test_mode0_basic();
    bit got;
    cfg(0, 0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 0);
    pulse_start(0);
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL m0_busy_rise: got %b expected 1", busy0); end
    wait_done(0, 400, got);
    checks++; if (!got) begin errors++; $display("FAIL m0_done_seen: got 0 expected 1"); end
    checks++; if ({pass0, errc0, tout0} !== {1'b1, 16'h0, 1'b0}) begin
      errors++; $display("FAIL m0_status: pass %b err_count %0d timeout %b expected 1 0 0", pass0, errc0, tout0); end
    checks++; if (wl_cnt !== 4 || r_cnt !== 4) begin
      errors++; $display("FAIL m0_counts: writes %0d reads %0d expected 4 4", wl_cnt, r_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wlog_a[i] !== 32'(i * 4)) begin
        errors++; $display("FAIL m0_addr[%0d]: got %h expected %h", i, wlog_a[i], 32'(i * 4)); end
      checks++; if (wlog_d[i] !== exp_d[i]) begin
        errors++; $display("FAIL m0_data[%0d]: got %h expected %h", i, wlog_d[i], exp_d[i]); end
    end
    checks++; if (ilv_bad !== 1'b0) begin errors++; $display("FAIL m0_interleave: got %b expected 0", ilv_bad); end
    @(posedge ACLK); #1;
    checks++; if ({done0, busy0, pass0} !== 3'b001) begin
      errors++; $display("FAIL m0_after_done: done busy pass %b expected 001", {done0, busy0, pass0}); end
  endtask

  task automatic test_mode1_random();
    bit got;
    cfg(1, 1, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 0);
    pulse_start(1);
    wait_done(1, 3000, got);
    checks++; if (!got) begin errors++; $display("FAIL m1_done_seen: got 0 expected 1"); end
    checks++; if ({pass1, errc1, tout1} !== {1'b1, 16'h0, 1'b0}) begin
      errors++; $display("FAIL m1_status: pass %b err_count %0d timeout %b expected 1 0 0", pass1, errc1, tout1); end
    checks++; if (aw_at_ar !== 8) begin errors++; $display("FAIL m1_writes_before_read: got %0d expected 8", aw_at_ar); end
    checks++; if (wl_cnt !== 8 || r_cnt !== 8) begin
      errors++; $display("FAIL m1_counts: writes %0d reads %0d expected 8 8", wl_cnt, r_cnt); end
    checks++; if (wlog_a[7] !== 32'h1C || wlog_d[7] !== 32'h7172706F) begin
      errors++; $display("FAIL m1_last_write: got %h/%h expected 0000001c/7172706f", wlog_a[7], wlog_d[7]); end
    checks++; if ({aw_first, w_first} !== 2'b11) begin
      errors++; $display("FAIL m1_both_orders: got %b expected 11", {aw_first, w_first}); end
  endtask

  task automatic test_data_corrupt();
    bit got;
    cfg(0, 0, 32'h8, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 0);
    pulse_start(0);
    wait_done(0, 400, got);
    checks++; if (!got) begin errors++; $display("FAIL corrupt_done_seen: got 0 expected 1"); end
    checks++; if ({pass0, errc0, fea0, tout0} !== {1'b0, 16'd1, 32'h8, 1'b0}) begin
      errors++; $display("FAIL corrupt_status: pass %b err_count %0d first %h timeout %b expected 0 1 8 0", pass0, errc0, fea0, tout0); end
  endtask

  task automatic test_slverr();
    bit got;
    cfg(0, 0, 32'hFFFF_FFF0, 32'h4, 32'hC, 0);
    pulse_start(0);
    wait_done(0, 400, got);
    checks++; if (!got) begin errors++; $display("FAIL slverr_done_seen: got 0 expected 1"); end
    checks++; if ({pass0, errc0, fea0} !== {1'b0, 16'd2, 32'h4}) begin
      errors++; $display("FAIL slverr_status: pass %b err_count %0d first %h expected 0 2 4", pass0, errc0, fea0); end
  endtask

  task automatic test_timeout();
    bit got;
    cfg(0, 0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 1);
    pulse_start(0);
    wait_done(0, 200, got);
    checks++; if (!got) begin errors++; $display("FAIL tmo_done_seen: got 0 expected 1"); end
    checks++; if (ar_hi !== 16) begin errors++; $display("FAIL tmo_arvalid_cycles: got %0d expected 16", ar_hi); end
    checks++; if ({tout0, errc0, pass0, fea0, m0.arvalid} !== {1'b1, 16'd1, 1'b0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL tmo_status: timeout %b err_count %0d pass %b first %h arvalid %b expected 1 1 0 0 0", tout0, errc0, pass0, fea0, m0.arvalid); end
    @(posedge ACLK); #1;
    checks++; if ({done0, busy0, tout0} !== 3'b001) begin
      errors++; $display("FAIL tmo_after_done: done busy timeout %b expected 001", {done0, busy0, tout0}); end
  endtask

  task automatic test_reset_mid_and_restart();
    bit got;
    cfg(0, 0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 0);
    pulse_start(0);
    checks++; if (m0.awvalid !== 1'b1) begin errors++; $display("FAIL rst_mid_awvalid_up: got %b expected 1", m0.awvalid); end
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    checks++; if ({m0.awvalid, m0.wvalid, m0.bready, m0.arvalid, m0.rready, busy0, done0, pass0, tout0} !== 9'b0) begin
      errors++; $display("FAIL rst_mid_ctl: got %b expected 000000000", {m0.awvalid, m0.wvalid, m0.bready, m0.arvalid, m0.rready, busy0, done0, pass0, tout0}); end
    ARESET = 1'b0;
    pulse_start(0);
    repeat (3) @(posedge ACLK);
    #1 start0 = 1'b1;
    @(posedge ACLK); #1 start0 = 1'b0;
    wait_done(0, 400, got);
    checks++; if (!got) begin errors++; $display("FAIL restart_done_seen: got 0 expected 1"); end
    checks++; if ({pass0, errc0} !== {1'b1, 16'h0} || wl_cnt !== 4 || r_cnt !== 4) begin
      errors++; $display("FAIL restart_status: pass %b err_count %0d writes %0d reads %0d expected 1 0 4 4", pass0, errc0, wl_cnt, r_cnt); end
    repeat (2) @(posedge ACLK);
    #1;
    checks++; if ({busy0, done0} !== 2'b00 || wl_cnt !== 4) begin
      errors++; $display("FAIL start_while_busy: busy %b done %b writes %0d expected 0 0 4", busy0, done0, wl_cnt); end
  endtask

  initial begin
    test_reset();
    test_mode0_basic();
    test_mode1_random();
    test_data_corrupt();
    test_slverr();
    test_timeout();
    test_reset_mid_and_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_lite_selftest_master.md
Name: axi_lite_selftest_master

Overview:
- Synthesizable, parametrised AXI4-Lite master that writes a generated pattern to NUM_REGS slave registers, reads each back and checks data and response.
- Supersedes the simulation-only BFM write/readback flow; drops into block designs in front of any AXI4-Lite slave IP for on-hardware register checks.
- Adds a configurable register count, stride and data width, two sequencing modes, response and timeout checking, and a status/error report.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_M_AXI_DATA_WIDTH, 32, data width; 32 or 64.
- NUM_REGS, 4, registers exercised; 1..256.
- BASE_ADDR, 32'h0, first register address.
- ADDR_STRIDE, 4, byte step between registers.
- MODE, 0, 0 = write/read per register (interleaved); 1 = write all registers, then read all.
- PATTERN_SEED, 32'h0101FFFF, data for register 0.
- PATTERN_INC, 32'h10101010, data increment per register, modulo 2^C_M_AXI_DATA_WIDTH.
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for any single handshake.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  valid once done fires; 1 when err_count==0; held until the next start.
- err_count  out  16  number of errors seen; saturates at 16'hFFFF.
- first_err_addr  out  C_M_AXI_ADDR_WIDTH  address of the first error; 0 if there was none.
- timeout  out  1  sticky; set on a handshake timeout.
- m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  ADDR/3/1/1  write address channel.
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DATA/DATA/8/1/1  write data channel.
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel.
- m_axi_araddr/arprot/arvalid/arready  out/out/out/in  ADDR/3/1/1  read address channel.
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA/2/1/1  read data channel.

Behaviour:
- Clock and reset: one clock, ACLK. Reset is synchronous, active-high, port ARESET.
- Reset values: all valids/readies 0; busy, done, pass, timeout 0; err_count 0; first_err_addr 0; state IDLE; index 0.
- Fixed outputs: awprot = arprot = 3'b000; wstrb = all ones.
- Register address for index i: BASE_ADDR + i*ADDR_STRIDE, truncated to C_M_AXI_ADDR_WIDTH; wraps silently.
- Expected data for index i: PATTERN_SEED + i*PATTERN_INC, truncated to the data width.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH.
- IDLE: on start, clear status, set index = 0, go to WR_REQ. busy rises the next cycle.
- WR_REQ:
  - awvalid and wvalid assert together.
  - Each valid drops the cycle after its own ready is seen (aw and w handshakes are independent, in either order or the same cycle).
  - When both channels are accepted, bready = 1 and go to WR_RESP.
  - Payloads stay stable while valid is high.
- WR_RESP:
  - On bvalid&&bready, bready drops; bresp != 2'b00 is an error.
  - MODE0: go to RD_REQ for the same index.
  - MODE1: increment index; after the last register, reset index to 0 and go to RD_REQ; otherwise go to WR_REQ.
- RD_REQ: arvalid high until arready; then rready = 1 and go to RD_RESP.
- RD_RESP:
  - On rvalid&&rready, capture rdata.
  - rresp != OKAY is one error. A data mismatch is one error. Both together count as two.
  - On the last index go to FINISH; otherwise increment index and go to WR_REQ (MODE0) or RD_REQ (MODE1).
- Error recording: first_err_addr latches on the first error only. err_count saturates.
- Timeout:
  - A per-state counter resets on every state entry.
  - Reaching TIMEOUT_CYCLES in any wait state: set timeout, count one error, drop all valid/ready, go to FINISH (abort).
- FINISH: one cycle. done = 1; pass = (err_count==0); busy drops; return to IDLE.
- start while busy is ignored.
- ARESET mid-transaction returns to reset values immediately. No handshake is completed after reset; the slave must also be reset.
- Throughput: with ready held high, MODE0 takes 4 cycles per register plus slave latency.

Test Plan:
- Defaults, MODE0, zero-latency RAM slave, start pulse → 4 write/read pairs at 0x0, 0x4, 0x8, 0xC. Data 0x0101FFFF, 0x1112100F, 0x2122201F, 0x3132302F. done after the last read; pass=1, err_count=0.
- MODE1, NUM_REGS=8, slave with random 0–5 cycle ready/valid delays → all 8 AW/W handshakes precede the first AR; pass=1. AW and W arrive in both orders.
- Slave corrupts the register at 0x8 (bit 0 flipped) → err_count=1, first_err_addr=0x8, pass=0.
- Slave returns SLVERR on the write to 0x4 and on the read of 0xC → err_count=2, first_err_addr=0x4.
- TIMEOUT_CYCLES=16, arready stuck at 0 → arvalid drops after 16 cycles; timeout=1, err_count=1, done pulses, pass=0.
- ARESET asserted during WR_REQ with awvalid high → all outputs at reset values the next cycle. A new start then completes with pass=1. A start pulse while busy has no effect.
